// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the multi-thread PC sequencer and the stages
// that reuse its round-robin arbiter.
package pc_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Thread-ID width; a single-thread build still carries a one-bit ID.
  function automatic int tid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, scanning upward and wrapping back to index 0.
module rr_arbiter
  import pc_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = tid_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_grant
);

  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic          hi_found;
  logic          lo_found;

  // Walking downward leaves the lowest match in each half; the upper half
  // (index >= ptr) wins, otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(j);
        if (j >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(j);
        end
      end
    end
    any_grant = lo_found;
    grant     = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-thread IF-stage PC sequencer with round-robin issue, stall, redirect
// bypass and start/halt control. Optional macro PC_ALIGN_CHECK_EN drops misaligned redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter int              NUM_THREADS   = 4,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter logic [XLEN-1:0] THREAD_STRIDE = '0,
  parameter int              PC_INC        = 4,
  localparam int             TIDW          = tid_width(NUM_THREADS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   halt_i,
  input  logic                   stall_i,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   redirect_valid_i,
  input  logic [TIDW-1:0]        redirect_tid_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic [XLEN-1:0]        pc_o,
  output logic [TIDW-1:0]        tid_o,
  output logic                   valid_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                   misalign_o,
  output logic [TIDW-1:0]        misalign_tid_o
`endif
);

  seq_state_e      state_q;
  logic [XLEN-1:0] pc_q [NUM_THREADS];
  logic [TIDW-1:0] rr_ptr;
  logic [TIDW-1:0] grant;
  logic            any_grant;
  logic            redir_ok;
  logic            bypass;
  logic [XLEN-1:0] eff_pc;
  logic [TIDW-1:0] next_ptr;

  rr_arbiter #(
    .N  (NUM_THREADS),
    .PW (TIDW)
  ) u_arb (
    .req       (thread_en_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_INC - 1);
  logic misaligned;
  assign misaligned = |(redirect_pc_i & ALIGN_MASK);
  assign redir_ok   = redirect_valid_i & ~misaligned;
`else
  assign redir_ok   = redirect_valid_i;
`endif

  assign bypass   = redir_ok && (redirect_tid_i == grant);
  assign eff_pc   = bypass ? redirect_pc_i : pc_q[grant];
  assign next_ptr = (int'(grant) == NUM_THREADS - 1) ? '0 : grant + 1'b1;

  // Redirects land first; an issue to the same thread later in this block
  // overrides its entry with the post-increment bypass value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rr_ptr  <= '0;
      pc_o    <= '0;
      tid_o   <= '0;
      valid_o <= 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC + XLEN'(t) * THREAD_STRIDE;
      end
`ifdef PC_ALIGN_CHECK_EN
      misalign_o     <= 1'b0;
      misalign_tid_o <= '0;
`endif
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (redir_ok && (redirect_tid_i == TIDW'(t))) begin
          pc_q[t] <= redirect_pc_i;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      misalign_o <= redirect_valid_i && misaligned;
      if (redirect_valid_i && misaligned) begin
        misalign_tid_o <= redirect_tid_i;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          valid_o <= 1'b0;
          if (start_i && !halt_i) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_i) begin
            state_q <= ST_IDLE;
            valid_o <= 1'b0;
          end else if (!stall_i) begin
            if (any_grant) begin
              pc_o        <= eff_pc;
              tid_o       <= grant;
              valid_o     <= 1'b1;
              pc_q[grant] <= eff_pc + XLEN'(PC_INC);
              rr_ptr      <= next_ptr;
            end else begin
              valid_o <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
